bus_txn_arbiter: RTL and testbench

Round-robin transaction arbiter that shares the single serial bus master (the 8-bit-address, 8-bit-read-data MOSI/MISO/SCLK link to the four slave devices) between four on-chip requesters. It accepts one read request per requester, grants the master to one requester at a time and drives the master's address and start strobe. It waits for the master to finish, returns the read byte to the granted requester and optionally aborts hung transactions with a watchdog. It sits between the requesting logic and `master_device`.

---
 rtl/bus_txn_arbiter.sv | 147 ++++++++++++++
 tb/tb_bus_txn_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_txn_arbiter.sv
// Round-robin arbiter that shares one serial bus master among four read requesters.
// Optional watchdog on the WAIT state is built when BUS_ARB_TIMEOUT_EN is defined.
module bus_txn_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  REQ,
    input  logic [31:0] REQ_ADDR,
    output logic [3:0]  GNT,
    output logic [3:0]  RSP_VALID,
    output logic [7:0]  RSP_DATA,
    output logic        RSP_ERR,
    output logic        M_START,
    output logic [7:0]  M_ADDR,
    input  logic        M_DONE,
    input  logic [7:0]  M_DATA,
    output logic [7:0]  TO_COUNT,
    output logic [1:0]  DBG_STATE
);

    // Handshake: a requester holds REQ (and its address slice) as a level until its
    // one-cycle RSP_VALID; M_START and M_DONE are single-cycle strobes, M_ADDR is held.
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr, ptr_d;
    logic [1:0] sel_idx;
    logic [1:0] gnt_idx, gnt_idx_d;
    logic       expired;

    logic [3:0] gnt_d, rsp_valid_d;
    logic [7:0] rsp_data_d, m_addr_d;
    logic       rsp_err_d, m_start_d;

    assign DBG_STATE = state;

    // Scan downwards so the requester closest to ptr overwrites the others.
    always_comb begin
        sel_idx = ptr;
        for (int i = 3; i >= 0; i--) begin
            if (REQ[ptr + 2'(i)]) sel_idx = ptr + 2'(i);
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    logic [7:0] wd_cnt;
    logic [7:0] to_cnt;

    assign expired  = (state == S_WAIT) && (wd_cnt == 8'(TIMEOUT - 1));
    assign TO_COUNT = to_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wd_cnt <= 8'h00;
            to_cnt <= 8'h00;
        end else begin
            if (state == S_ISSUE) wd_cnt <= 8'h00;
            else if (state == S_WAIT) wd_cnt <= wd_cnt + 8'h01;
            // A completion in the expiry cycle is not a timeout.
            if (expired && !M_DONE && to_cnt != 8'hFF) to_cnt <= to_cnt + 8'h01;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign expired        = 1'b0;
    assign TO_COUNT       = 8'h00;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (|REQ) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (M_DONE || expired) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values for the registered outputs; everything leaves through flops.
    always_comb begin
        gnt_d       = GNT;
        gnt_idx_d   = gnt_idx;
        rsp_valid_d = 4'b0000;
        rsp_data_d  = RSP_DATA;
        rsp_err_d   = RSP_ERR;
        m_start_d   = 1'b0;
        m_addr_d    = M_ADDR;
        ptr_d       = ptr;
        case (state)
            S_IDLE: begin
                if (|REQ) begin
                    gnt_d     = 4'b0001 << sel_idx;
                    gnt_idx_d = sel_idx;
                    m_addr_d  = REQ_ADDR[{sel_idx, 3'b000} +: 8];
                    m_start_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (M_DONE) begin
                    rsp_data_d  = M_DATA;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = GNT;
                end else if (expired) begin
                    rsp_data_d  = 8'h00;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = GNT;
                end
            end
            S_RESP: begin
                gnt_d = 4'b0000;
                ptr_d = gnt_idx + 2'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            GNT       <= 4'b0000;
            gnt_idx   <= 2'd0;
            RSP_VALID <= 4'b0000;
            RSP_DATA  <= 8'h00;
            RSP_ERR   <= 1'b0;
            M_START   <= 1'b0;
            M_ADDR    <= 8'h00;
            ptr       <= 2'd0;
        end else begin
            GNT       <= gnt_d;
            gnt_idx   <= gnt_idx_d;
            RSP_VALID <= rsp_valid_d;
            RSP_DATA  <= rsp_data_d;
            RSP_ERR   <= rsp_err_d;
            M_START   <= m_start_d;
            M_ADDR    <= m_addr_d;
            ptr       <= ptr_d;
        end
    end

endmodule

// File: tb/tb_bus_txn_arbiter.sv
// Bench for bus_txn_arbiter: vector table, hand sequences, and randomized traffic
// checked against a round-robin reference model.
module tb_bus_txn_arbiter;

    localparam int TB_TIMEOUT = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  REQ;
    logic [31:0] REQ_ADDR;
    logic [3:0]  GNT;
    logic [3:0]  RSP_VALID;
    logic [7:0]  RSP_DATA;
    logic        RSP_ERR;
    logic        M_START;
    logic [7:0]  M_ADDR;
    logic        M_DONE;
    logic [7:0]  M_DATA;
    logic [7:0]  TO_COUNT;
    logic [1:0]  dbg_state;

    bus_txn_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_ADDR(REQ_ADDR),
        .GNT(GNT), .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
        .M_START(M_START), .M_ADDR(M_ADDR), .M_DONE(M_DONE), .M_DATA(M_DATA),
        .TO_COUNT(TO_COUNT), .DBG_STATE(dbg_state)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int ptr_m  = 0;
    logic [12:0] exp_q[$];   // {rsp_valid, rsp_data, rsp_err}

    typedef struct {
        logic [3:0]  req;
        logic [31:0] addr;
        int          delay;
        logic [7:0]  data;
        logic [3:0]  exp_gnt;
        logic [7:0]  exp_addr;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] req, input int p);
        for (int i = 0; i < 4; i++) begin
            if (req[(p + i) % 4]) return (p + i) % 4;
        end
        return 0;
    endfunction

    task automatic apply_reset();
        RST = 1'b1; REQ = 4'b0; REQ_ADDR = 32'h0; M_DONE = 1'b0; M_DATA = 8'h00;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        ptr_m = 0;
        exp_q.delete();
        @(negedge CLK);
    endtask

    task automatic wait_start();
        for (int n = 0; n < 20 && !M_START; n++) @(negedge CLK);
        check("m_start_seen", M_START, 1);
    endtask

    task automatic check_rsp(input string name);
        logic [12:0] e;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_queue actual=empty expected=entry", name);
        end else begin
            e = exp_q.pop_front();
            check({name, "_valid"}, RSP_VALID, e[12:9]);
            check({name, "_data"}, RSP_DATA, e[8:1]);
            check({name, "_err"}, RSP_ERR, e[0]);
        end
    endtask

    // driver: one transaction from request to the IDLE cycle after the response
    task automatic run_txn(input logic [3:0] req, input logic [31:0] addr, input int delay,
                           input logic [7:0] data, input bit early, input bit drop,
                           input logic [3:0] exp_gnt, input logic [7:0] exp_addr);
        REQ = req; REQ_ADDR = addr;
        exp_q.push_back({exp_gnt, data, 1'b0});
        wait_start();
        check("gnt", GNT, exp_gnt);
        check("m_addr", M_ADDR, exp_addr);
        if (drop) REQ = 4'b0;
        if (early) begin M_DONE = 1'b1; M_DATA = ~data; end
        @(negedge CLK);
        check("m_start_pulse", M_START, 0);
        M_DONE = 1'b0;
        repeat (delay) @(negedge CLK);
        M_DONE = 1'b1; M_DATA = data;
        @(negedge CLK);
        M_DONE = 1'b0;
        check_rsp("rsp");
        @(negedge CLK);
        check("rsp_pulse", RSP_VALID, 0);
        check("gnt_idle", GNT, 0);
        for (int i = 0; i < 4; i++) if (exp_gnt[i]) ptr_m = (i + 1) % 4;
    endtask

    initial begin
        logic [3:0]  req;
        logic [31:0] addr;
        logic [7:0]  data;
        int          idx;
        int          n;

        vecs[0] = '{4'b1111, 32'h2B2A1B1A, 0, 8'h11, 4'b0001, 8'h1A};
        vecs[1] = '{4'b1111, 32'h2B2A1B1A, 3, 8'h22, 4'b0010, 8'h1B};
        vecs[2] = '{4'b1111, 32'h2B2A1B1A, 1, 8'h33, 4'b0100, 8'h2A};
        vecs[3] = '{4'b1111, 32'h2B2A1B1A, 5, 8'h44, 4'b1000, 8'h2B};
        vecs[4] = '{4'b1111, 32'h2B2A1B1A, 2, 8'h55, 4'b0001, 8'h1A};
        vecs[5] = '{4'b0100, 32'h2B2A1B1A, 0, 8'h66, 4'b0100, 8'h2A};
        vecs[6] = '{4'b0101, 32'h2B2A1B1A, 4, 8'h77, 4'b0001, 8'h1A};

        apply_reset();
        check("rst_gnt", GNT, 0);
        check("rst_rsp_valid", RSP_VALID, 0);
        check("rst_rsp_data", RSP_DATA, 0);
        check("rst_rsp_err", RSP_ERR, 0);
        check("rst_m_start", M_START, 0);
        check("rst_m_addr", M_ADDR, 0);
        check("rst_to_count", TO_COUNT, 0);

        // single request
        run_txn(4'b0001, 32'h0000001A, 10, 8'h5D, 0, 0, 4'b0001, 8'h1A);
        REQ = 4'b0;

        // round-robin and pointer fairness from a fresh pointer
        apply_reset();
        for (int v = 0; v < 7; v++)
            run_txn(vecs[v].req, vecs[v].addr, vecs[v].delay, vecs[v].data, 0, 0,
                    vecs[v].exp_gnt, vecs[v].exp_addr);
        REQ = 4'b0;

        // randomized traffic against the model
        for (int t = 0; t < 40; t++) begin
            req  = 4'($urandom_range(1, 15));
            addr = $urandom;
            data = 8'($urandom);
            idx  = rr_pick(req, ptr_m);
            if ($urandom_range(0, 3) == 0) begin
                REQ = 4'b0;
                repeat ($urandom_range(1, 3)) @(negedge CLK);
            end
            run_txn(req, addr, $urandom_range(0, 6), data,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    4'b0001 << idx, 8'(addr >> (8 * idx)));
        end
        REQ = 4'b0;
        @(negedge CLK);

`ifdef BUS_ARB_TIMEOUT_EN
        // hung transaction
        REQ = 4'b0001; REQ_ADDR = 32'h000000C1;
        exp_q.push_back({4'b0001, 8'h00, 1'b1});
        wait_start();
        n = 0;
        while (RSP_VALID == 4'b0 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check("to_latency", n, TB_TIMEOUT + 1);
        check_rsp("to_rsp");
        check("to_count_1", TO_COUNT, 1);
        REQ = 4'b0;
        @(negedge CLK);
        ptr_m = 1;
        // completion in the expiry cycle wins
        run_txn(4'b0001, 32'h000000C2, TB_TIMEOUT - 1, 8'hC3, 0, 0, 4'b0001, 8'hC2);
        check("to_count_done_wins", TO_COUNT, 1);
        // saturation: hold a hung request through well over 255 timeouts
        REQ = 4'b0001;
        repeat (256 * (TB_TIMEOUT + 3)) @(negedge CLK);
        REQ = 4'b0;
        repeat (TB_TIMEOUT + 6) @(negedge CLK);
        check("to_count_sat", TO_COUNT, 8'hFF);
        check("sat_idle_gnt", GNT, 0);
        ptr_m = 1;
`else
        idx = rr_pick(4'b0010, ptr_m);
        run_txn(4'b0010, 32'h0000D500, 500, 8'hA5, 0, 0, 4'b0001 << idx, 8'hD5);
        check("no_wd_to_count", TO_COUNT, 0);
`endif

        // reset in WAIT
        run_txn(4'b0001, 32'h00000099, 1, 8'hE7, 0, 0, 4'b0001, 8'h99);
        REQ = 4'b0011; REQ_ADDR = 32'h00004433;
        wait_start();
        check("pre_rst_gnt", GNT, 4'b0010);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        #1;
        check("mid_rst_gnt", GNT, 0);
        check("mid_rst_m_start", M_START, 0);
        check("mid_rst_m_addr", M_ADDR, 0);
        check("mid_rst_rsp_data", RSP_DATA, 0);
        check("mid_rst_rsp_valid", RSP_VALID, 0);
        check("mid_rst_to_count", TO_COUNT, 0);
        @(negedge CLK);
        RST = 1'b0;
        ptr_m = 0;
        exp_q.delete();
        run_txn(4'b0011, 32'h00004433, 2, 8'h7E, 0, 0, 4'b0001, 8'h33);
        REQ = 4'b0;
        @(negedge CLK);
        check("exp_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
